// File: rtl/sap_counter_pkg.sv
// ---------------------------------------------------------------------------
// sap_counter_pkg
//
// Purpose:
//   Shared definitions for the SAP-U counter family. The counter slices and
//   anything that drives their 'up' input import this package so that count
//   direction is always written symbolically rather than as a bare 1/0.
//
// Contents:
//   CNT_UP / CNT_DOWN  - direction encodings for the 'up' input
//   defaultMaxCount()  - full-scale terminal value (2**width - 1) used as the
//                        default modulus when a slice is a plain binary counter
// ---------------------------------------------------------------------------
package sap_counter_pkg;

    // Direction encodings for the counter 'up' input.
    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

    // Full-scale terminal value for a counter of the given width.
    // The computation is done in 64 bits so that the shift never overflows
    // for the widths that can actually be represented in the return type;
    // a width of 64 or more saturates to all ones.
    function automatic longint unsigned defaultMaxCount(input int unsigned width);
        longint unsigned fullScale;
        if (width >= 64) begin
            fullScale = 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            fullScale = (64'd1 << width) - 64'd1;
        end
        return fullScale;
    endfunction

endpackage

// File: rtl/sn_counter_next.sv
// ---------------------------------------------------------------------------
// sn_counter_next
//
// Purpose:
//   Purely combinational next-state logic for one sn_updown_counter slice.
//   Given the present count and the control inputs it produces the value the
//   register should take on the next rising edge, the terminal-count flag and
//   the wrap indication used to set the sticky overflow flag.
//
// Ports:
//   i_q      [WIDTH] present counter value
//   i_up             1 = count up, 0 = count down
//   i_d      [WIDTH] parallel load data
//   i_sclrN          synchronous clear, active low (highest priority)
//   i_loadN          parallel load, active low
//   i_enp            parallel count enable
//   i_ent            trickle count enable
//   o_qNext  [WIDTH] value to register on the next edge
//   o_tc             terminal count for the current direction
//   o_wrap           a count is being taken from the terminal value
// ---------------------------------------------------------------------------
module sn_counter_next
    import sap_counter_pkg::*;
#(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MAX_COUNT = defaultMaxCount(WIDTH)
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_up,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_sclrN,
    input  logic             i_loadN,
    input  logic             i_enp,
    input  logic             i_ent,
    output logic [WIDTH-1:0] o_qNext,
    output logic             o_tc,
    output logic             o_wrap
);

    // Terminal value narrowed to the counter width once, so every comparison
    // below is a same-width unsigned compare.
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

    logic             w_atTop;
    logic             w_atZero;
    logic             w_countEn;
    logic [WIDTH-1:0] w_qInc;
    logic [WIDTH-1:0] w_qDec;

    // Terminal detection. Counting up treats anything at or above the
    // terminal value as terminal, so a value loaded above MAX_COUNT still
    // wraps to zero on the next up-count instead of running on to the
    // natural binary rollover.
    assign w_atTop  = (i_q >= MAX_Q);
    assign w_atZero = (i_q == '0);

    // tc depends only on the present value and direction; the enables are
    // applied later, in the rco gating of the top level.
    assign o_tc = (i_up == CNT_UP) ? w_atTop : w_atZero;

    // A count edge happens only when neither clear nor load claims the edge
    // and both enables are high. A count taken while tc is high is a wrap.
    assign w_countEn = i_sclrN & i_loadN & i_enp & i_ent;
    assign o_wrap    = w_countEn & o_tc;

    // Plain increment/decrement. Both sides are WIDTH bits and the results
    // are only used when the terminal cases are excluded, so the natural
    // modulo-2**WIDTH behaviour never leaks out.
    assign w_qInc = i_q + WIDTH'(1);
    assign w_qDec = i_q - WIDTH'(1);

    // Next-value selection in edge priority order: synchronous clear, then
    // load, then count, otherwise hold. Counting down from a value above
    // MAX_COUNT simply decrements; only an exact zero wraps back to MAX_COUNT.
    always_comb begin
        o_qNext = i_q;
        if (!i_sclrN) begin
            o_qNext = '0;
        end else if (!i_loadN) begin
            o_qNext = i_d;
        end else if (i_enp && i_ent) begin
            if (i_up == CNT_UP) begin
                o_qNext = w_atTop ? '0 : w_qInc;
            end else begin
                o_qNext = w_atZero ? MAX_Q : w_qDec;
            end
        end
    end

endmodule

// File: rtl/sn_updown_counter.sv
// ---------------------------------------------------------------------------
// sn_updown_counter
//
// Purpose:
//   Parametrised up/down counter slice for the SAP-U simulator, a drop-in
//   successor of the legacy 4-bit synchronous counter. It serves as program
//   counter, step counter and decade counter. Slices cascade by feeding the
//   rco of one slice into the ent of the next.
//
// Parameters:
//   WIDTH         counter width in bits (>= 1)
//   MAX_COUNT     terminal value when counting up, reload value when counting
//                 down past zero; 1 .. 2**WIDTH-1
//   RCO_USES_ENP  1: rco = tc & ent & enp (legacy behaviour)
//                 0: rco = tc & ent       (lookahead-style carry)
//
// Ports:
//   clk      rising-edge clock
//   clr_n    asynchronous clear, active low (clears q and ovf)
//   sclr_n   synchronous clear, active low
//   load_n   synchronous parallel load, active low
//   enp      parallel count enable
//   ent      trickle count enable, also gates rco
//   up       count direction (CNT_UP / CNT_DOWN)
//   ovf_clr  synchronous clear of the sticky wrap flag
//   d        parallel load data
//   q        counter value
//   tc       terminal count, combinational from q and up
//   rco      ripple carry/borrow out for cascading
//   ovf      sticky wrap flag, registered
// ---------------------------------------------------------------------------
module sn_updown_counter
    import sap_counter_pkg::*;
#(
    parameter int unsigned     WIDTH        = 4,
    parameter longint unsigned MAX_COUNT    = defaultMaxCount(WIDTH),
    parameter bit              RCO_USES_ENP = 1'b1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             sclr_n,
    input  logic             load_n,
    input  logic             enp,
    input  logic             ent,
    input  logic             up,
    input  logic             ovf_clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             rco,
    output logic             ovf
);

    // Largest value representable in WIDTH bits, used to reject a modulus
    // that the counter register could never hold.
    localparam longint unsigned FULL_SCALE = defaultMaxCount(WIDTH);

    // Refuse to elaborate with a zero width or a terminal value outside
    // 1 .. 2**WIDTH-1; such a slice would have no meaningful wrap point.
    if ((WIDTH < 1) || (MAX_COUNT < 1) || (MAX_COUNT > FULL_SCALE)) begin : g_paramCheck
        $fatal(1, "sn_updown_counter: WIDTH=%0d MAX_COUNT=%0d is not a legal combination",
               WIDTH, MAX_COUNT);
    end

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;
    logic [WIDTH-1:0] w_qNext;
    logic             w_tc;
    logic             w_wrap;
    logic             w_rcoEnp;

    // All next-value arithmetic and terminal detection lives in the
    // combinational helper; this level only owns the state and the gating.
    sn_counter_next #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT)
    ) u_next (
        .i_q     (r_q),
        .i_up    (up),
        .i_d     (d),
        .i_sclrN (sclr_n),
        .i_loadN (load_n),
        .i_enp   (enp),
        .i_ent   (ent),
        .o_qNext (w_qNext),
        .o_tc    (w_tc),
        .o_wrap  (w_wrap)
    );

    // Counter and sticky wrap flag. The asynchronous clear forces both to
    // zero at once, independent of the clock, and holds them there while
    // clr_n stays low. A synchronous clear also drops the flag; otherwise a
    // wrap sets it, and a wrap on the same edge as ovf_clr still sets it so
    // that a wrap is never lost.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_q   <= '0;
            r_ovf <= 1'b0;
        end else if (!sclr_n) begin
            r_q   <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_q <= w_qNext;
            if (w_wrap) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // The legacy part also gated its carry with enp; the lookahead variant
    // lets the carry ripple ahead of the parallel enable so that a chain of
    // slices settles in one gate delay per slice.
    assign w_rcoEnp = RCO_USES_ENP ? enp : 1'b1;

    // Outputs: tc and rco are combinational so a cascaded slice sees the
    // carry in the same cycle that this slice reaches its terminal value.
    assign q   = r_q;
    assign ovf = r_ovf;
    assign tc  = w_tc;
    assign rco = w_tc & ent & w_rcoEnp;

endmodule
